// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver push side, FWFT read side and status bundle; master drives rx/read/clear, slave is the FIFO
interface uart_rx_fifo_if #(parameter int AW = 4);
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        rd_ready;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [AW:0] count;
  logic        full;
  logic        almost_full;
  logic        overrun;
  logic        overrun_clr;
  modport master (
    output rx_data, rx_done, rd_ready, overrun_clr,
    input  rd_valid, rd_data, count, full, almost_full, overrun
  );
  modport slave (
    input  rx_data, rx_done, rd_ready, overrun_clr,
    output rd_valid, rd_data, count, full, almost_full, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive byte FIFO; ports clk, reset_n (async active-low), bus (rx_data/rx_done in, FWFT rd_valid/rd_data/rd_ready out, count/full/almost_full/overrun status, overrun_clr)
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int AF_LEVEL = 12
) (
  input logic           clk,
  input logic           reset_n,
  uart_rx_fifo_if.slave bus
);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_rx_done_d, r_overrun;
  logic          w_push_req, w_pop, w_full, w_push;
  assign w_full     = r_count == (AW+1)'(DEPTH);
  assign w_push_req = bus.rx_done && !r_rx_done_d;
  assign w_pop      = (r_count != '0) && bus.rd_ready;
  assign w_push     = w_push_req && (!w_full || w_pop);
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= bus.rx_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rx_done_d <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_done_d <= bus.rx_done;
      r_wr_ptr    <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr    <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_count     <= (w_push && !w_pop) ? r_count + 1'b1 : (w_pop && !w_push) ? r_count - 1'b1 : r_count;
      r_overrun   <= (w_push_req && w_full && !w_pop) ? 1'b1 : bus.overrun_clr ? 1'b0 : r_overrun;
    end
  assign bus.rd_valid    = r_count != '0;
  assign bus.rd_data     = bus.rd_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign bus.count       = r_count;
  assign bus.full        = w_full;
  assign bus.almost_full = r_count >= (AW+1)'(AF_LEVEL);
  assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scenarios plus randomized traffic checked against a queue model of the FIFO
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] m_q[$];
  bit   m_prev = 1'b0;
  bit   m_ovr = 1'b0;
  uart_rx_fifo_if #(.AW(4)) bus ();
  uart_rx_fifo #(.DEPTH(DEPTH), .AW(4), .AF_LEVEL(AF)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    bit pr, pp, fm;
    @(posedge clk);
    pr = bus.rx_done && !m_prev;
    pp = (m_q.size() != 0) && bus.rd_ready;
    fm = m_q.size() == DEPTH;
    if (pp) void'(m_q.pop_front());
    if (pr && (!fm || pp)) m_q.push_back(bus.rx_data);
    if (pr && fm && !pp) m_ovr = 1'b1;
    else if (bus.overrun_clr) m_ovr = 1'b0;
    m_prev = bus.rx_done;
    @(negedge clk);
  endtask
  task automatic put(input logic [7:0] d);
    bus.rx_data = d;
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    tick();
  endtask
  task automatic pop();
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
  endtask
  task automatic test_reset();
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.rd_ready = 1'b0;
    bus.overrun_clr = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 ||
        bus.full !== 1'b0 || bus.almost_full !== 1'b0 || bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset: count=%0d valid=%b data=%h full=%b af=%b ovr=%b, want all zero",
               bus.count, bus.rd_valid, bus.rd_data, bus.full, bus.almost_full, bus.overrun);
    end
    reset_n = 1'b1;
    m_q.delete();
    m_prev = 1'b0;
    m_ovr = 1'b0;
  endtask
  task automatic test_single();
    bus.rx_data = 8'hA5;
    bus.rx_done = 1'b1;
    tick();
    total++;
    if (bus.count !== 5'd1 || bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5) begin
      bad++;
      $display("FAIL single_first: count=%0d valid=%b data=%h, want 1 1 a5", bus.count, bus.rd_valid, bus.rd_data);
    end
    repeat (15) tick();
    bus.rx_done = 1'b0;
    total++;
    if (bus.count !== 5'd1) begin
      bad++;
      $display("FAIL single_hold: count=%0d, want 1", bus.count);
    end
    pop();
    total++;
    if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00) begin
      bad++;
      $display("FAIL single_pop: count=%0d valid=%b data=%h, want 0 0 00", bus.count, bus.rd_valid, bus.rd_data);
    end
  endtask
  task automatic test_order_wrap();
    int nxt = 0;
    for (int i = 0; i < 12; i++) put(8'(i));
    for (int i = 0; i < 8; i++) begin
      total++;
      if (bus.rd_data !== 8'(nxt)) begin
        bad++;
        $display("FAIL order_a: got %h want %h", bus.rd_data, 8'(nxt));
      end
      nxt++;
      pop();
    end
    for (int i = 12; i < 20; i++) put(8'(i));
    for (int i = 0; i < 12; i++) begin
      total++;
      if (bus.rd_data !== 8'(nxt)) begin
        bad++;
        $display("FAIL order_b: got %h want %h", bus.rd_data, 8'(nxt));
      end
      nxt++;
      pop();
    end
    total++;
    if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL order_end: count=%0d valid=%b, want 0 0", bus.count, bus.rd_valid);
    end
  endtask
  task automatic test_full_overrun();
    for (int i = 0; i < 16; i++) begin
      put(8'(8'h10 + i));
      if (i == 10) begin
        total++;
        if (bus.almost_full !== 1'b0) begin
          bad++;
          $display("FAIL af_11: got %b want 0", bus.almost_full);
        end
      end
      if (i == 11) begin
        total++;
        if (bus.almost_full !== 1'b1 || bus.full !== 1'b0) begin
          bad++;
          $display("FAIL af_12: af=%b full=%b want 1 0", bus.almost_full, bus.full);
        end
      end
    end
    total++;
    if (bus.full !== 1'b1 || bus.almost_full !== 1'b1 || bus.count !== 5'd16 || bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL full16: full=%b af=%b count=%0d ovr=%b want 1 1 16 0", bus.full, bus.almost_full, bus.count, bus.overrun);
    end
    put(8'h20);
    total++;
    if (bus.overrun !== 1'b1 || bus.count !== 5'd16) begin
      bad++;
      $display("FAIL overrun: ovr=%b count=%0d want 1 16", bus.overrun, bus.count);
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (bus.rd_data !== 8'(8'h10 + i)) begin
        bad++;
        $display("FAIL full_drain: got %h want %h", bus.rd_data, 8'(8'h10 + i));
      end
      pop();
    end
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00) begin
      bad++;
      $display("FAIL full_empty: valid=%b data=%h want 0 00", bus.rd_valid, bus.rd_data);
    end
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
  endtask
  task automatic test_simul_full();
    for (int i = 0; i < 16; i++) put(8'(8'h40 + i));
    bus.rx_data = 8'h77;
    bus.rx_done = 1'b1;
    bus.rd_ready = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    bus.rd_ready = 1'b0;
    total++;
    if (bus.count !== 5'd16 || bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL simul: count=%0d ovr=%b want 16 0", bus.count, bus.overrun);
    end
    for (int i = 1; i < 17; i++) begin
      total++;
      if (bus.rd_data !== ((i == 16) ? 8'h77 : 8'(8'h40 + i))) begin
        bad++;
        $display("FAIL simul_drain: got %h want %h", bus.rd_data, (i == 16) ? 8'h77 : 8'(8'h40 + i));
      end
      pop();
    end
  endtask
  task automatic test_overrun_clr();
    for (int i = 0; i < 17; i++) put(8'(i * 3));
    total++;
    if (bus.overrun !== 1'b1) begin
      bad++;
      $display("FAIL clr_set: ovr=%b want 1", bus.overrun);
    end
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    total++;
    if (bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL clr_alone: ovr=%b want 0", bus.overrun);
    end
    bus.rx_data = 8'hEE;
    bus.rx_done = 1'b1;
    bus.overrun_clr = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    bus.overrun_clr = 1'b0;
    total++;
    if (bus.overrun !== 1'b1 || bus.count !== 5'd16) begin
      bad++;
      $display("FAIL clr_vs_set: ovr=%b count=%0d want 1 16", bus.overrun, bus.count);
    end
    tick();
    for (int i = 0; i < 16; i++) pop();
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) put(8'(8'hC0 + i));
    total++;
    if (bus.count !== 5'd5 || bus.overrun !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: count=%0d ovr=%b want 5 1", bus.count, bus.overrun);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (bus.count !== 5'd0 || bus.rd_valid !== 1'b0 || bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: count=%0d valid=%b ovr=%b want 0 0 0", bus.count, bus.rd_valid, bus.overrun);
    end
    m_q.delete();
    m_prev = 1'b0;
    m_ovr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    put(8'h3C);
    total++;
    if (bus.count !== 5'd1 || bus.rd_data !== 8'h3C) begin
      bad++;
      $display("FAIL post_reset: count=%0d data=%h want 1 3c", bus.count, bus.rd_data);
    end
    pop();
  endtask
  task automatic test_random();
    logic [7:0] exp_d;
    for (int i = 0; i < 600; i++) begin
      if (!bus.rx_done) bus.rx_data = 8'($urandom);
      bus.rx_done = ($urandom_range(0, 2) == 0) ? !bus.rx_done : bus.rx_done;
      bus.rd_ready = (i < 300) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 6);
      bus.overrun_clr = $urandom_range(0, 29) == 0;
      tick();
      exp_d = (m_q.size() != 0) ? m_q[0] : 8'h00;
      total++;
      if (bus.count !== 5'(m_q.size()) || bus.rd_valid !== (m_q.size() != 0) || bus.rd_data !== exp_d ||
          bus.full !== (m_q.size() == DEPTH) || bus.almost_full !== (m_q.size() >= AF) || bus.overrun !== m_ovr) begin
        bad++;
        $display("FAIL random[%0d]: count=%0d valid=%b data=%h full=%b af=%b ovr=%b want count=%0d data=%h ovr=%b",
                 i, bus.count, bus.rd_valid, bus.rd_data, bus.full, bus.almost_full, bus.overrun,
                 m_q.size(), exp_d, m_ovr);
      end
    end
    bus.rx_done = 1'b0;
    bus.rd_ready = 1'b0;
    bus.overrun_clr = 1'b0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_order_wrap();
    test_full_overrun();
    test_simul_full();
    test_overrun_clr();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
